// File: rtl/sobel_defs.sv
// Shared constants and the RGB565 -> 8-bit luma conversion for the Sobel edge stage.
package sobel_defs;

  localparam int IMG_W_DEF = 256;
  localparam int IMG_H_DEF = 256;

  // BT.601-style luma weights scaled by 256; they sum to 256 so the result fits 8 bits.
  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  // Edge magnitudes above this value are clamped.
  localparam logic [7:0] SAT_MAX = 8'd255;

  // Expand each channel to 8 bits by replicating its MSBs, then weight and drop 8 LSBs.
  // Worst case 77*255 + 150*255 + 29*255 = 65280, so 16 bits never overflow.
  function automatic logic [7:0] rgb565_to_gray(input logic [15:0] px);
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] acc;
    r8  = {px[15:11], px[15:13]};
    g8  = {px[10:5], px[10:9]};
    b8  = {px[4:0], px[4:2]};
    acc = 16'(COEF_R) * 16'(r8) + 16'(COEF_G) * 16'(g8) + 16'(COEF_B) * 16'(b8);
    return acc[15:8];
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-line pixel store: single port, registered read-first access so it maps onto block RAM.
module sobel_line_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:DEPTH-1];
  logic [DW-1:0] r_rdata;

  // Each access returns the old word at i_addr and replaces it with i_wdata.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_rdata       <= r_mem[i_addr];
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sobel_edge_stage.sv
// Streaming RGB565 -> grayscale -> 3x3 Sobel edge stage with coordinate and end-of-frame tags.
// Valid/ready contract: there is no back-pressure; a pixel is accepted in every cycle
// in_valid is high, and out_valid is a one-cycle strobe that the consumer must take.
// Pipeline: input (gray + L1 access) -> s0 (L2 access) -> s1 (column align)
//           -> window -> output register; out_valid follows in_valid by 4 clocks.
module sobel_edge_stage
  import sobel_defs::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int XW    = 8,
  parameter int YW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [15:0]   in_data,
  input  logic          thresh_en,
  input  logic [7:0]    threshold,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_eof
);

  // Input position counters
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic [XW-1:0] w_x_nxt;
  logic [YW-1:0] w_y_nxt;
  logic [7:0]    w_gray;

  // Position of the current pixel (sof forces 0,0) and the position that follows it.
  always_comb begin
    w_x     = in_sof ? '0 : r_x;
    w_y     = in_sof ? '0 : r_y;
    w_x_nxt = w_x + XW'(1);
    w_y_nxt = w_y;
    if (w_x == XW'(IMG_W - 1)) begin
      w_x_nxt = '0;
      w_y_nxt = (w_y == YW'(IMG_H - 1)) ? '0 : w_y + YW'(1);
    end
  end

  // Counters advance only on accepted pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (in_valid) begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
    end
  end

  assign w_gray = rgb565_to_gray(in_data);

  // Stage 0: gray value with its coordinates
  logic          r_s0_valid;
  logic [7:0]    r_s0_gray;
  logic [XW-1:0] r_s0_x;
  logic [YW-1:0] r_s0_y;

  // Stage 0 valid bit is cleared by reset so in-flight pixels are dropped.
  always_ff @(posedge clk) begin
    if (rst) r_s0_valid <= 1'b0;
    else     r_s0_valid <= in_valid;
  end

  // Stage 0 payload captured alongside the valid bit.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_s0_gray <= w_gray;
      r_s0_x    <= w_x;
      r_s0_y    <= w_y;
    end
  end

  // Line buffers: L1 holds row y-1, L2 holds row y-2. L1 is accessed with the input
  // pixel; the row it displaces is pushed into L2 one cycle later at the same column.
  logic [7:0] w_l1_rd;
  logic [7:0] w_l2_rd;
  logic       w_l1_en;

  assign w_l1_en = in_valid & ~rst;

  sobel_line_buffer #(.DEPTH(IMG_W), .AW(XW), .DW(8)) u_line1 (
    .clk     (clk),
    .i_en    (w_l1_en),
    .i_addr  (w_x),
    .i_wdata (w_gray),
    .o_rdata (w_l1_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .AW(XW), .DW(8)) u_line2 (
    .clk     (clk),
    .i_en    (r_s0_valid),
    .i_addr  (r_s0_x),
    .i_wdata (w_l1_rd),
    .o_rdata (w_l2_rd)
  );

  // Stage 1: holds gray and the L1 word so they line up with the later L2 read.
  logic          r_s1_valid;
  logic [7:0]    r_s1_gray;
  logic [7:0]    r_s1_l1;
  logic [XW-1:0] r_s1_x;
  logic [YW-1:0] r_s1_y;

  // Stage 1 valid bit.
  always_ff @(posedge clk) begin
    if (rst) r_s1_valid <= 1'b0;
    else     r_s1_valid <= r_s0_valid;
  end

  // Stage 1 payload: current pixel, row y-1 at the same column, coordinates.
  always_ff @(posedge clk) begin
    if (r_s0_valid) begin
      r_s1_gray <= r_s0_gray;
      r_s1_l1   <= w_l1_rd;
      r_s1_x    <= r_s0_x;
      r_s1_y    <= r_s0_y;
    end
  end

  // 3x3 window, indexed [row][col]; row 0 = y-2, col 2 = newest column (x).
  logic          r_w_valid;
  logic [7:0]    r_win [0:2][0:2];
  logic [XW-1:0] r_w_x;
  logic [YW-1:0] r_w_y;

  // Window valid bit.
  always_ff @(posedge clk) begin
    if (rst) r_w_valid <= 1'b0;
    else     r_w_valid <= r_s1_valid;
  end

  // Shift the window left and insert the new column; gaps leave it untouched.
  always_ff @(posedge clk) begin
    if (r_s1_valid) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_l2_rd;
      r_win[1][2] <= r_s1_l1;
      r_win[2][2] <= r_s1_gray;
      r_w_x       <= r_s1_x;
      r_w_y       <= r_s1_y;
    end
  end

  // Gradients as 11-bit two's complement, magnitude |gx|+|gy| (max 2040).
  logic [9:0]  w_gx_p;
  logic [9:0]  w_gx_n;
  logic [9:0]  w_gy_p;
  logic [9:0]  w_gy_n;
  logic [10:0] w_gx;
  logic [10:0] w_gy;
  logic [10:0] w_agx;
  logic [10:0] w_agy;
  logic [10:0] w_mag;
  logic [7:0]  w_sat;
  logic [7:0]  w_level;
  logic [7:0]  w_pix;
  logic        w_emit;
  logic        w_border;
  logic        w_eof;

  // Sobel kernels, saturation, border forcing and optional binarisation.
  always_comb begin
    w_gx_p = {2'b00, r_win[0][2]} + {1'b0, r_win[1][2], 1'b0} + {2'b00, r_win[2][2]};
    w_gx_n = {2'b00, r_win[0][0]} + {1'b0, r_win[1][0], 1'b0} + {2'b00, r_win[2][0]};
    w_gy_p = {2'b00, r_win[2][0]} + {1'b0, r_win[2][1], 1'b0} + {2'b00, r_win[2][2]};
    w_gy_n = {2'b00, r_win[0][0]} + {1'b0, r_win[0][1], 1'b0} + {2'b00, r_win[0][2]};
    w_gx   = {1'b0, w_gx_p} - {1'b0, w_gx_n};
    w_gy   = {1'b0, w_gy_p} - {1'b0, w_gy_n};
    w_agx  = w_gx[10] ? (~w_gx + 11'd1) : w_gx;
    w_agy  = w_gy[10] ? (~w_gy + 11'd1) : w_gy;
    w_mag  = w_agx + w_agy;
    w_sat  = (w_mag > 11'(SAT_MAX)) ? SAT_MAX : w_mag[7:0];
    // Newest column x, centre x-1: emit only when the centre exists (x>=1, y>=1).
    w_emit   = r_w_valid && (r_w_x != '0) && (r_w_y != '0);
    // Centre on row 0 or column 0 has no complete window.
    w_border = (r_w_x == XW'(1)) || (r_w_y == YW'(1));
    w_level  = w_border ? 8'd0 : w_sat;
    w_pix    = thresh_en ? ((w_level >= threshold) ? SAT_MAX : 8'd0) : w_level;
    w_eof    = (r_w_x == XW'(IMG_W - 1)) && (r_w_y == YW'(IMG_H - 1));
  end

  // Output register: strobe every cycle, payload updated only on emitted pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      out_data  <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= w_emit;
      out_eof   <= w_emit & w_eof;
      if (w_emit) begin
        out_data <= w_pix;
        out_x    <= r_w_x - XW'(1);
        out_y    <= r_w_y - YW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_stage.sv
// Directed bench for sobel_edge_stage on a reduced 16x8 frame with a 2-D image reference.
module tb_sobel_edge_stage;

  localparam int IMG_W = 16;
  localparam int IMG_H = 8;
  localparam int XW    = 4;
  localparam int YW    = 3;
  localparam int W     = 1 + YW + XW + 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sof;
  logic [15:0]   in_data;
  logic          thresh_en;
  logic [7:0]    threshold;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          out_eof;

  sobel_edge_stage #(.IMG_W(IMG_W), .IMG_H(IMG_H), .XW(XW), .YW(YW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .thresh_en (thresh_en),
    .threshold (threshold),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_eof   (out_eof)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model state ----------------
  logic [7:0]   img [0:IMG_H-1][0:IMG_W-1];
  int           gray_lut [0:255];
  int           bx, by;
  int           checks = 0;
  int           errors = 0;
  int           n_pushed = 0;
  int           n_dropped = 0;
  int           n_seen = 0;
  int           n_eof = 0;
  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];

  function automatic int gray_of(input logic [15:0] d);
    int r8, g8, b8;
    r8 = (int'(d[15:11]) << 3) | (int'(d[15:11]) >> 2);
    g8 = (int'(d[10:5]) << 2) | (int'(d[10:5]) >> 4);
    b8 = (int'(d[4:0]) << 3) | (int'(d[4:0]) >> 2);
    return (77 * r8 + 150 * g8 + 29 * b8) >> 8;
  endfunction

  // Sobel magnitude around centre (cx,cy) of the reference image, clamped to 255.
  function automatic int sobel_at(input int cx, input int cy);
    int gx, gy, wgt, m;
    gx = 0;
    gy = 0;
    for (int k = 0; k < 3; k++) begin
      wgt = (k == 1) ? 2 : 1;
      gx += wgt * (int'(img[cy-1+k][cx+1]) - int'(img[cy-1+k][cx-1]));
      gy += wgt * (int'(img[cy+1][cx-1+k]) - int'(img[cy-1][cx-1+k]));
    end
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  // Data whose gray value is 5*x (nearest reachable value below if 5*x has no code).
  function automatic logic [15:0] ramp_px(input int x);
    int g;
    g = 5 * x;
    while (g > 0 && gray_lut[g] < 0) g--;
    return 16'(gray_lut[g] < 0 ? 0 : gray_lut[g]);
  endfunction

  function automatic logic [15:0] pix_of(input int mode, input int x, input int y);
    case (mode)
      0:       return 16'hFFFF;
      1:       return (x < IMG_W / 2) ? 16'h0000 : 16'hFFFF;
      3:       return ramp_px(x);
      default: return 16'($urandom_range(0, 65535) + y * 0);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Drives one cycle; on a valid pixel updates the model and queues the expected output.
  task automatic drive_px(input logic v, input logic sof, input logic [15:0] d);
    int   cx, cy, lvl, pix;
    logic eb;
    @(posedge clk);
    #1;
    in_valid = v;
    in_sof   = sof;
    in_data  = d;
    if (v) begin
      if (sof) begin
        bx = 0;
        by = 0;
      end
      img[by][bx] = 8'(gray_of(d));
      if (bx >= 1 && by >= 1) begin
        cx  = bx - 1;
        cy  = by - 1;
        lvl = (cx == 0 || cy == 0) ? 0 : sobel_at(cx, cy);
        pix = thresh_en ? ((lvl >= int'(threshold)) ? 255 : 0) : lvl;
        eb  = (cx == IMG_W - 2) && (cy == IMG_H - 2);
        exp_q.push_back({eb, YW'(cy), XW'(cx), 8'(pix)});
        exp_t_q.push_back(cyc + 4);
        n_pushed++;
      end
      if (bx == IMG_W - 1) begin
        bx = 0;
        by = (by == IMG_H - 1) ? 0 : by + 1;
      end else begin
        bx++;
      end
    end
  endtask

  // Drives up to npix pixels of a frame starting with sof; gap 1 = alternate, 2 = random.
  task automatic run_frame(input int mode, input int gap, input int npix);
    int n;
    n = 0;
    for (int y = 0; y < IMG_H; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        if (n < npix) begin
          if (gap == 1 && n > 0) drive_px(1'b0, 1'b0, 16'h0000);
          else if (gap == 2 && $urandom_range(0, 2) == 0) drive_px(1'b0, 1'b0, 16'h0000);
          drive_px(1'b1, (n == 0), pix_of(mode, x, y));
          n++;
        end
      end
    end
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] obs;
  logic [W-1:0] e_word;
  int           e_time;

  always @(negedge clk) begin
    if (out_valid) begin
      n_seen++;
      if (out_eof) n_eof++;
      obs = {out_eof, out_y, out_x, out_data};
      checks++;
      assert (exp_q.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_out got %h want none at cyc %0d", obs, cyc);
      end
      if (exp_q.size() != 0) begin
        e_word = exp_q.pop_front();
        e_time = exp_t_q.pop_front();
        checks++;
        assert (obs === e_word)
        else begin
          errors++;
          $error("FAIL out_pixel got {eof,y,x,data}=%h want %h at cyc %0d", obs, e_word, cyc);
        end
        checks++;
        assert (cyc === e_time)
        else begin
          errors++;
          $error("FAIL latency got cyc %0d want cyc %0d", cyc, e_time);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  int base_seen;
  int base_eof;
  int rst_cyc;

  initial begin
    for (int g = 0; g < 256; g++) gray_lut[g] = -1;
    for (int d = 0; d < 65536; d++) begin
      if (gray_lut[gray_of(16'(d))] < 0) gray_lut[gray_of(16'(d))] = d;
    end
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = 16'h0000;
    thresh_en = 1'b0;
    threshold = 8'd0;
    bx        = 0;
    by        = 0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; assert (out_valid === 1'b0) else begin errors++; $error("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; assert (out_data === 8'd0) else begin errors++; $error("FAIL rst_out_data got %h want 00", out_data); end
    checks++; assert (out_x === XW'(0)) else begin errors++; $error("FAIL rst_out_x got %0d want 0", out_x); end
    checks++; assert (out_y === YW'(0)) else begin errors++; $error("FAIL rst_out_y got %0d want 0", out_y); end
    checks++; assert (out_eof === 1'b0) else begin errors++; $error("FAIL rst_out_eof got %b want 0", out_eof); end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Flat white frame: every output 0, (W-1)*(H-1) strobes, one eof
    base_seen = n_seen;
    base_eof  = n_eof;
    run_frame(0, 0, IMG_W * IMG_H);
    drain();
    checks++;
    assert (n_seen - base_seen === (IMG_W - 1) * (IMG_H - 1))
    else begin errors++; $error("FAIL flat_count got %0d want %0d", n_seen - base_seen, (IMG_W - 1) * (IMG_H - 1)); end
    checks++;
    assert (n_eof - base_eof === 1)
    else begin errors++; $error("FAIL flat_eof_count got %0d want 1", n_eof - base_eof); end

    // Vertical step, then a random frame back-to-back with no idle cycle
    run_frame(1, 0, IMG_W * IMG_H);
    run_frame(2, 0, IMG_W * IMG_H);
    drain();

    // Input gaps: strict alternation, then random gaps
    run_frame(2, 1, IMG_W * IMG_H);
    run_frame(2, 2, IMG_W * IMG_H);
    drain();

    // Binarised ramp with magnitude 40: threshold 41 then 40
    thresh_en = 1'b1;
    threshold = 8'd41;
    run_frame(3, 0, IMG_W * IMG_H);
    drain();
    threshold = 8'd40;
    run_frame(3, 0, IMG_W * IMG_H);
    drain();

    // Threshold 0: every emitted pixel, borders included, is 255
    threshold = 8'd0;
    run_frame(2, 0, IMG_W * IMG_H);
    drain();

    // Mid-frame resync: sof lands where (10,5) would have been
    thresh_en = 1'b0;
    run_frame(2, 0, 5 * IMG_W + 10);
    run_frame(2, 0, IMG_W * IMG_H);
    drain();

    // Reset one cycle mid-frame: in-flight pixels are dropped
    run_frame(2, 0, 50);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst      = 1'b1;
    rst_cyc  = cyc;
    while (exp_t_q.size() != 0 && exp_t_q[exp_t_q.size() - 1] >= rst_cyc + 1) begin
      void'(exp_q.pop_back());
      void'(exp_t_q.pop_back());
      n_dropped++;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bx  = 0;
    by  = 0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      assert (out_valid === 1'b0)
      else begin errors++; $error("FAIL post_rst_quiet got out_valid %b want 0 at cyc %0d", out_valid, cyc); end
    end
    run_frame(2, 2, IMG_W * IMG_H);
    drain();

    // Every queued result was produced, and nothing else
    checks++;
    assert (exp_q.size() === 0)
    else begin errors++; $error("FAIL pending_expected got %0d left want 0", exp_q.size()); end
    checks++;
    assert (n_seen === n_pushed - n_dropped)
    else begin errors++; $error("FAIL total_outputs got %0d want %0d", n_seen, n_pushed - n_dropped); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_edge_stage.md
Name: sobel_edge_stage

Overview:
Streaming edge-detection stage between the camera pixel assembler and the frame buffer write port.
- Consumes RGB565 pixels qualified by a valid strobe and converts each one to 8-bit grayscale.
- Runs a 3x3 Sobel operator over an IMG_W x IMG_H window using two on-chip line buffers.
- Emits one 8-bit edge pixel per accepted input pixel (once the window is primed), together with buffer coordinates and an end-of-frame flag, for direct use as buffer write data and address.

Parameters:
IMG_W, 256, pixels per line processed; input x counter wraps at IMG_W.
IMG_H, 256, lines per frame processed; input y counter wraps at IMG_H.
XW, 8, width of x coordinate ports (clog2 IMG_W).
YW, 8, width of y coordinate ports (clog2 IMG_H).

Ports:
clk  in  1  single clock for all logic.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  input pixel strobe; one pixel per cycle when high, gaps allowed.
in_sof  in  1  start of frame; qualified by in_valid; marks pixel (0,0).
in_data  in  16  RGB565 pixel: R[15:11], G[10:5], B[4:0].
thresh_en  in  1  1 = binary output, 0 = magnitude output.
threshold  in  8  binarisation threshold.
out_valid  out  1  output pixel strobe.
out_data  out  8  edge magnitude or binary value.
out_x  out  XW  column of the output (centre) pixel.
out_y  out  YW  row of the output (centre) pixel.
out_eof  out  1  high with the last output pixel of the frame.

Behaviour:
Reset:
- out_valid, out_eof, out_data, out_x and out_y are all 0.
- x/y counters are 0.
- Pipeline valid bits are cleared. Line buffer contents are not cleared.

Input counters (advance only when in_valid=1):
- in_valid & in_sof: the pixel is treated as (0,0); next position is (1,0).
- Otherwise x increments. At x=IMG_W-1, x goes to 0 and y increments; y wraps IMG_H-1 -> 0.
- in_sof mid-frame resynchronises immediately. Pipeline contents in flight still drain.

Stage 0 (grayscale):
- Expand channels: r8={R,R[4:2]}, g8={G,G[5:4]}, b8={B,B[4:2]}.
- gray = (77*r8 + 150*g8 + 29*b8) >> 8, computed in 16-bit unsigned; the result is always <= 255.
- The gray value, x, y and valid are registered together.

Stage 1 (window):
- On a valid pixel, read line buffers L1 (row y-1) and L2 (row y-2) at address x. Read is before write in the same cycle.
- Write L1[x] <= gray and L2[x] <= old L1[x].
- Shift the 3x3 window left and insert the column {L2, L1, gray}.
- The window shifts only on valid.

Stage 2 (gradients, signed 11-bit):
- gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20).
- gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02).

Stage 3 (magnitude):
- mag = |gx| + |gy| as 11-bit unsigned, max 2040; saturate to 255.
- thresh_en=1: out_data = (mag >= threshold) ? 255 : 0.

Output emission:
- out_valid is produced for an input pixel at (x,y) only when x>=1 and y>=1.
- The output centre is (x-1, y-1). Column IMG_W-1 and row IMG_H-1 are never emitted.
- Centre with x-1=0 or y-1=0: out_data is forced to 0 (window incomplete).
- Latency: out_valid rises exactly 4 clk cycles after the accepted in_valid. The fixed pipeline registers a bubble for every gap in in_valid.
- out_eof=1 only together with centre (IMG_W-2, IMG_H-2).

Boundaries:
- threshold=0 with thresh_en=1 makes every emitted pixel 255, including borders.
- Back-to-back frames need no idle cycles.
- rst mid-frame drops in-flight pixels (no out_valid in the following cycles) and restarts at (0,0).

Decomposition:
- Shared header sobel_defs: IMG_W/IMG_H defaults, the luma coefficients 77/150/29, and the saturation limit 255.
- One sub-module, sobel_line_buffer: single clock, depth IMG_W, 8-bit, read-before-write, one port. It is instantiated twice so it maps to block RAM.
- The window, gradient and magnitude logic stay in sobel_edge_stage.

Test Plan:
- Flat frame (in_data=16'hFFFF for all 256x256 pixels, thresh_en=0) -> 65025 out_valid pulses, all out_data=0, and one out_eof at (254,254).
- Vertical step (columns x<128 = 16'h0000, x>=128 = 16'hFFFF) -> out_data=255 at out_x=127 and 128 for rows 1..254, and 0 elsewhere.
- Latency/gaps: in_valid toggled 1,0,1,0 from (0,1) on -> each out_valid is exactly 4 cycles after its in_valid; out_x/out_y match x-1/y-1.
- Threshold: ramp image with gradient magnitude 40, thresh_en=1 -> threshold=41 gives all 0; threshold=40 gives interior 255.
- Resync: in_sof asserted at input (100,50) -> the next output appears at in (1,1), centre (0,0), with out_data=0 (border); the counter restart is verified.
- Reset mid-frame: rst for 1 cycle at input pixel 3000 -> no out_valid for the next 4 cycles; the next frame starting with in_sof matches the reference model.
